inst_queue: RTL and testbench

- Instruction queue between the instruction cache and the dual-issue decode stage.
- Accepts up to two fetched instructions per cycle, with their PCs, from the fetch stage. These are the cache's two read-data words gated by its two per-word ok flags.
- Presents up to two oldest instructions per cycle to decode.
- Decouples cache miss stalls from decode back-pressure. Supports a single-cycle flush on redirect.

---
 rtl/inst_queue.sv | 130 +++++++++++++
 tb/tb_inst_queue.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// Dual-issue instruction queue between the I-cache fetch stage and decode.
// Two write lanes (tail, tail+1) and two read lanes (head, head+1) over a DEPTH-entry ring.

module inst_queue_lane #(
  parameter  int DEPTH = 8,
  parameter  int LANE  = 0,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [PTR_W-1:0] tail,
  input  logic [PTR_W-1:0] head,
  input  logic [PTR_W:0]   count,
  input  logic [1:0]       enq_n,
  input  logic [31:0]      in_pc,
  output logic             wr_en,
  output logic [PTR_W-1:0] wr_idx,
  output logic [31:0]      wr_pc,
  output logic             rd_vld,
  output logic [PTR_W-1:0] rd_idx
);
  // Pointer sums wrap modulo DEPTH through the PTR_W-bit width.
  assign wr_en  = enq_n > 2'(LANE);
  assign wr_idx = tail + PTR_W'(LANE);
  assign wr_pc  = in_pc + 32'(4 * LANE);
  assign rd_vld = count > (PTR_W+1)'(LANE);
  assign rd_idx = head + PTR_W'(LANE);
endmodule

module inst_queue #(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid1,
  input  logic             in_valid2,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_inst1,
  input  logic [31:0]      in_inst2,
  output logic             iq_full,
  output logic             out_valid1,
  output logic             out_valid2,
  output logic [31:0]      out_inst1,
  output logic [31:0]      out_pc1,
  output logic [31:0]      out_inst2,
  output logic [31:0]      out_pc2,
  input  logic [1:0]       deq_num,
  output logic [PTR_W:0]   iq_count
);
  localparam int NUM_LANES = 2;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [1:0]       enq_n, deq_sat, deq_eff;

  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];

  logic [NUM_LANES-1:0]            wr_en, rd_vld;
  logic [NUM_LANES-1:0][PTR_W-1:0] wr_idx, rd_idx;
  logic [NUM_LANES-1:0][31:0]      wr_pc, wr_inst;

  assign wr_inst[0] = in_inst1;
  assign wr_inst[1] = in_inst2;

  // Full means fewer than two free slots, so a dual enqueue can never overflow.
  assign iq_full = count_q > (PTR_W+1)'(DEPTH - 2);
  assign enq_n   = (iq_full || !in_valid1) ? 2'd0 : (in_valid2 ? 2'd2 : 2'd1);
  assign deq_sat = deq_num[1] ? 2'd2 : {1'b0, deq_num[0]};
  assign deq_eff = ((PTR_W+1)'(deq_sat) > count_q) ? count_q[1:0] : deq_sat;

  genvar l;
  generate
    for (l = 0; l < NUM_LANES; l++) begin : g_lane
      inst_queue_lane #(.DEPTH(DEPTH), .LANE(l)) u_lane (
        .tail   (tail_q),
        .head   (head_q),
        .count  (count_q),
        .enq_n  (enq_n),
        .in_pc  (in_pc),
        .wr_en  (wr_en[l]),
        .wr_idx (wr_idx[l]),
        .wr_pc  (wr_pc[l]),
        .rd_vld (rd_vld[l]),
        .rd_idx (rd_idx[l])
      );
    end
  endgenerate

  always_comb begin
    head_d  = head_q + PTR_W'(deq_eff);
    tail_d  = tail_q + PTR_W'(enq_n);
    count_d = count_q + (PTR_W+1)'(enq_n) - (PTR_W+1)'(deq_eff);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload array is intentionally not reset; validity comes from count_q alone.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (wr_en[i] && !flush) begin
        pc_mem[wr_idx[i]]   <= wr_pc[i];
        inst_mem[wr_idx[i]] <= wr_inst[i];
      end
    end
  end

  assign out_valid1 = rd_vld[0];
  assign out_valid2 = rd_vld[1];
  assign out_pc1    = pc_mem[rd_idx[0]];
  assign out_inst1  = inst_mem[rd_idx[0]];
  assign out_pc2    = pc_mem[rd_idx[1]];
  assign out_inst2  = inst_mem[rd_idx[1]];
  assign iq_count   = count_q;
endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: directed corner cases pinned by literals, then random traffic vs a queue model.

module tb_inst_queue;
  localparam int DEPTH = 8;
  localparam int PTR_W = $clog2(DEPTH);

  logic             clk = 0;
  logic             rst = 0;
  logic             flush = 0;
  logic             in_valid1 = 0, in_valid2 = 0;
  logic [31:0]      in_pc = 0, in_inst1 = 0, in_inst2 = 0;
  logic             iq_full, out_valid1, out_valid2;
  logic [31:0]      out_inst1, out_pc1, out_inst2, out_pc2;
  logic [1:0]       deq_num = 0;
  logic [PTR_W:0]   iq_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;
  ent_t mq[$];

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid1(in_valid1), .in_valid2(in_valid2),
    .in_pc(in_pc), .in_inst1(in_inst1), .in_inst2(in_inst2),
    .iq_full(iq_full), .out_valid1(out_valid1), .out_valid2(out_valid2),
    .out_inst1(out_inst1), .out_pc1(out_pc1),
    .out_inst2(out_inst2), .out_pc2(out_pc2),
    .deq_num(deq_num), .iq_count(iq_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int n = mq.size();
    chk("out_valid1", 32'(out_valid1), 32'(n >= 1));
    chk("out_valid2", 32'(out_valid2), 32'(n >= 2));
    chk("iq_full",    32'(iq_full),    32'(DEPTH - n < 2));
    chk("iq_count",   32'(iq_count),   32'(n));
    if (n >= 1) begin
      chk("out_pc1",   out_pc1,   mq[0].pc);
      chk("out_inst1", out_inst1, mq[0].inst);
    end
    if (n >= 2) begin
      chk("out_pc2",   out_pc2,   mq[1].pc);
      chk("out_inst2", out_inst2, mq[1].inst);
    end
  endtask

  // Drive one cycle's inputs, advance the model, then check just after the edge.
  task automatic cyc(input bit v1, input bit v2, input logic [31:0] pc,
                     input logic [31:0] i1, input logic [31:0] i2,
                     input logic [1:0] dq, input bit fl);
    int n, deq, want;
    bit full;
    @(negedge clk);
    in_valid1 = v1; in_valid2 = v2; in_pc = pc;
    in_inst1 = i1; in_inst2 = i2; deq_num = dq; flush = fl;
    n    = mq.size();
    full = (DEPTH - n) < 2;
    if (fl) begin
      mq.delete();
    end else begin
      want = (dq == 2'd3) ? 2 : int'(dq);
      deq  = (want < n) ? want : n;
      repeat (deq) void'(mq.pop_front());
      if (v1 && !full) begin
        mq.push_back('{pc: pc, inst: i1});
        if (v2) mq.push_back('{pc: pc + 32'd4, inst: i2});
      end
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 32'h0, 32'h0, 32'h0, 2'd0, 0);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #2 rst = 0;
    #1;
    chk("rst_valid1", 32'(out_valid1), 32'd0);
    chk("rst_valid2", 32'(out_valid2), 32'd0);
    chk("rst_full",   32'(iq_full),    32'd0);
    chk("rst_count",  32'(iq_count),   32'd0);
    mq.delete();
    @(negedge clk);
    in_valid1 = 0; in_valid2 = 0; deq_num = 0; flush = 0;
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    // Power-on reset held low, then released away from the clock edge.
    repeat (2) @(posedge clk);
    #1;
    chk("por_valid1", 32'(out_valid1), 32'd0);
    chk("por_full",   32'(iq_full),    32'd0);
    chk("por_count",  32'(iq_count),   32'd0);
    @(negedge clk);
    rst = 1;
    idle(1);

    // Dual enqueue: slot-2 PC is slot-1 PC + 4.
    cyc(1, 1, 32'hBFC00000, 32'h11111111, 32'h22222222, 2'd0, 0);
    chk("dual_count", 32'(iq_count), 32'd2);
    chk("dual_pc1",   out_pc1,   32'hBFC00000);
    chk("dual_pc2",   out_pc2,   32'hBFC00004);
    chk("dual_inst1", out_inst1, 32'h11111111);
    chk("dual_inst2", out_inst2, 32'h22222222);

    // Fill to full, then one dropped enqueue.
    cyc(1, 1, 32'h00001000, 32'hA0, 32'hA1, 2'd0, 0);
    cyc(1, 1, 32'h00002000, 32'hB0, 32'hB1, 2'd0, 0);
    chk("six_full",   32'(iq_full), 32'd0);
    cyc(1, 1, 32'h00003000, 32'hC0, 32'hC1, 2'd0, 0);
    chk("full_flag",  32'(iq_full), 32'd1);
    chk("full_count", 32'(iq_count), 32'd8);
    cyc(1, 1, 32'h00004000, 32'hD0, 32'hD1, 2'd0, 0);
    chk("drop_count", 32'(iq_count), 32'd8);
    chk("drop_head",  out_pc1, 32'hBFC00000);

    // Drain to head=7, count=1, tail=0; then enqueue 2 and dequeue 1 across the wrap.
    cyc(0, 0, 32'h0, 32'h0, 32'h0, 2'd2, 0);
    cyc(0, 0, 32'h0, 32'h0, 32'h0, 2'd3, 0);
    cyc(0, 0, 32'h0, 32'h0, 32'h0, 2'd2, 0);
    cyc(0, 0, 32'h0, 32'h0, 32'h0, 2'd1, 0);
    chk("pre_wrap_count", 32'(iq_count), 32'd1);
    chk("pre_wrap_pc",    out_pc1, 32'h00003004);
    cyc(1, 1, 32'hFFFFFFFC, 32'hE0, 32'hE1, 2'd1, 0);
    chk("wrap_count", 32'(iq_count), 32'd2);
    chk("wrap_pc1",   out_pc1,   32'hFFFFFFFC);
    chk("wrap_pc2",   out_pc2,   32'h00000000);
    chk("wrap_inst2", out_inst2, 32'hE1);

    // Over-dequeue with one entry left.
    cyc(0, 0, 32'h0, 32'h0, 32'h0, 2'd1, 0);
    cyc(0, 0, 32'h0, 32'h0, 32'h0, 2'd2, 0);
    chk("over_count",  32'(iq_count), 32'd0);
    chk("over_valid1", 32'(out_valid1), 32'd0);

    // Flush beats a same-cycle enqueue and dequeue.
    cyc(1, 1, 32'h00005000, 32'hF0, 32'hF1, 2'd0, 0);
    cyc(1, 1, 32'h00005008, 32'hF2, 32'hF3, 2'd0, 0);
    cyc(1, 0, 32'h00005010, 32'hF4, 32'hF5, 2'd0, 0);
    chk("pre_flush_count", 32'(iq_count), 32'd5);
    cyc(1, 1, 32'h00006000, 32'h77, 32'h78, 2'd2, 1);
    chk("flush_count",  32'(iq_count), 32'd0);
    chk("flush_valid1", 32'(out_valid1), 32'd0);
    cyc(1, 0, 32'h00007000, 32'h99, 32'h0, 2'd0, 0);
    chk("post_flush_pc",   out_pc1, 32'h00007000);
    chk("post_flush_inst", out_inst1, 32'h99);
    chk("post_flush_v2",   32'(out_valid2), 32'd0);

    // Slot-2 valid alone must not enqueue.
    cyc(0, 1, 32'h00008000, 32'h55, 32'h56, 2'd0, 0);
    chk("v2_only_count", 32'(iq_count), 32'd1);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      bit v1 = ($urandom_range(0, 9) < 7);
      bit v2 = $urandom_range(0, 1);
      logic [31:0] pc = {$urandom(), 2'b00};
      logic [1:0] dq = 2'($urandom_range(0, 3));
      bit fl = ($urandom_range(0, 99) < 2);
      if (i % 500 < 250 && dq != 0) dq = 2'($urandom_range(0, 1));
      cyc(v1, v2, pc, $urandom(), $urandom(), dq, fl);
      if (i == 1500) begin
        cyc(1, 1, 32'h0000A000, 32'h1, 32'h2, 2'd0, 0);
        mid_reset();
        cyc(1, 1, 32'h0000B000, 32'h3, 32'h4, 2'd0, 0);
        chk("post_rst_pc1", out_pc1, 32'h0000B000);
        chk("post_rst_count", 32'(iq_count), 32'd2);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
